tp_ntt_feeder: RTL and testbench

TP_NTT_FEEDER -- requirements
Module: tp_ntt_feeder

---
 rtl/tp_ntt_feeder.sv | 178 +++++++++++++++++
 tb/tb_tp_ntt_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_ntt_feeder.sv
// tp_ntt_feeder: double-buffered polynomial feeder for a TP-lane NTT core.
// Upstream beats fill one of two banks while the other bank streams out.
// Streaming is gapless, with a one-cycle START_NTT_ALL on beat 0.
// Successive starts are kept at least MIN_GAP clocks apart.
// Optional build macro TP_NTT_FEEDER_CSUB_EN: each stored lane gets one
// conditional subtraction of q on write.
module tp_ntt_feeder #(
  parameter int unsigned N       = 1 << 16,
  parameter int unsigned TP      = 1 << 6,
  parameter int unsigned LOGQ    = 32,
  parameter int unsigned MIN_GAP = 1 << 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TP*LOGQ-1:0]   in_data,
  input  logic [1:0]           in_op_type,
  input  logic [LOGQ-1:0]      in_q,
  output logic                 START_NTT_ALL,
  output logic [1:0]           OP_TYPE_INPUT,
  output logic [LOGQ-1:0]      Q_in,
  output logic [TP*LOGQ-1:0]   NTT_INPUT,
  output logic                 busy
);

  localparam int unsigned DEPTH = N / TP;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned GW    = $clog2(MIN_GAP + 1);
  localparam int unsigned W     = TP * LOGQ;

  typedef enum logic [1:0] {BankEmpty, BankFilling, BankFull, BankDraining} bank_state_e;
  typedef enum logic [0:0] {StIdle, StStream} tx_state_e;

  bank_state_e       bank_q [2];
  bank_state_e       bank_d [2];
  logic [1:0]        op_bank_q [2];
  logic [LOGQ-1:0]   q_bank_q [2];
  logic [W-1:0]      mem [2][DEPTH];

  logic              wp_q, wp_d, rp_q;
  logic [AW-1:0]     wcnt_q, wcnt_d, rcnt_q;
  logic [GW-1:0]     gap_q;
  tx_state_e         state_q;

  logic              in_fire, fill_first, fill_last;
  logic              gap_ok, drain_take, drain_done;
  logic              in_ready_d, busy_d;
  logic [W-1:0]      wr_data;

  assign in_fire    = in_valid & in_ready;
  assign fill_first = (wcnt_q == '0);
  assign fill_last  = (wcnt_q == AW'(DEPTH - 1));

  // The decision edge precedes the visible pulse by one cycle, and the counter reads 0
  // in the pulse cycle, so a decision in cycle g yields a pulse in cycle g+2.
  assign gap_ok     = (32'(gap_q) + 32'd2) >= MIN_GAP;
  assign drain_take = (state_q == StIdle) && (bank_q[rp_q] == BankFull) && gap_ok;
  assign drain_done = (state_q == StStream) && (rcnt_q == AW'(DEPTH - 1));

`ifdef TP_NTT_FEEDER_CSUB_EN
  logic [LOGQ-1:0] q_eff;
  // Beat 0 has not latched q yet, so it uses the live modulus.
  assign q_eff = fill_first ? in_q : q_bank_q[wp_q];
`endif

  // Lane conditioning applied on the write path.
  always_comb begin
    wr_data = in_data;
`ifdef TP_NTT_FEEDER_CSUB_EN
    for (int i = 0; i < int'(TP); i++) begin
      if (in_data[i*LOGQ +: LOGQ] >= q_eff) begin
        wr_data[i*LOGQ +: LOGQ] = in_data[i*LOGQ +: LOGQ] - q_eff;
      end
    end
`endif
  end

  // Bank bookkeeping: fill side and drain side never touch a bank in the same state.
  always_comb begin
    bank_d = bank_q;
    wp_d   = wp_q;
    wcnt_d = wcnt_q;
    if (drain_take) bank_d[rp_q] = BankDraining;
    if (drain_done) bank_d[rp_q] = BankEmpty;
    if (in_fire) begin
      if (fill_first) bank_d[wp_q] = BankFilling;
      if (fill_last) begin
        bank_d[wp_q] = BankFull;
        wcnt_d       = '0;
        wp_d         = ~wp_q;
      end else begin
        wcnt_d = wcnt_q + AW'(1);
      end
    end
    in_ready_d = (bank_d[wp_d] == BankEmpty) || (bank_d[wp_d] == BankFilling);
    busy_d     = (bank_d[0] != BankEmpty) || (bank_d[1] != BankEmpty) ||
                 (state_q == StStream);
  end

  // Fill-side state, per-bank metadata and registered handshake/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]    <= BankEmpty;
      bank_q[1]    <= BankEmpty;
      op_bank_q[0] <= '0;
      op_bank_q[1] <= '0;
      q_bank_q[0]  <= '0;
      q_bank_q[1]  <= '0;
      wp_q         <= 1'b0;
      wcnt_q       <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      wp_q     <= wp_d;
      wcnt_q   <= wcnt_d;
      in_ready <= in_ready_d;
      busy     <= busy_d;
      if (in_fire && fill_first) begin
        op_bank_q[wp_q] <= in_op_type;
        q_bank_q[wp_q]  <= in_q;
      end
    end
  end

  // Bank storage; contents are only meaningful once the bank is FULL.
  always_ff @(posedge clk) begin
    if (in_fire) mem[wp_q][wcnt_q] <= wr_data;
  end

  // Transmit FSM: read address leads the registered output by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rp_q          <= 1'b0;
      rcnt_q        <= '0;
      gap_q         <= GW'(MIN_GAP);
      START_NTT_ALL <= 1'b0;
      NTT_INPUT     <= '0;
      OP_TYPE_INPUT <= '0;
      Q_in          <= '0;
    end else begin
      START_NTT_ALL <= 1'b0;
      NTT_INPUT     <= '0;
      if ((state_q == StStream) && (rcnt_q == '0)) begin
        gap_q <= '0;
      end else if (gap_q != GW'(MIN_GAP)) begin
        gap_q <= gap_q + GW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (drain_take) begin
            state_q <= StStream;
            rcnt_q  <= '0;
          end
        end
        StStream: begin
          NTT_INPUT     <= mem[rp_q][rcnt_q];
          START_NTT_ALL <= (rcnt_q == '0);
          if (rcnt_q == '0) begin
            OP_TYPE_INPUT <= op_bank_q[rp_q];
            Q_in          <= q_bank_q[rp_q];
          end
          if (drain_done) begin
            state_q <= StIdle;
            rp_q    <= ~rp_q;
            rcnt_q  <= '0;
          end else begin
            rcnt_q <= rcnt_q + AW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tp_ntt_feeder.sv
// Bench for tp_ntt_feeder: directed steps in one initial block; expected beats are
// queued on each accepted input beat and compared when the stream comes out.
module tb_tp_ntt_feeder;

  localparam int N       = 256;
  localparam int TP      = 16;
  localparam int LOGQ    = 32;
  localparam int MIN_GAP = 20;
  localparam int DEPTH   = N / TP;
  localparam int W       = TP * LOGQ;

  logic            clk, rst, in_valid, in_ready, START_NTT_ALL, busy;
  logic [W-1:0]    in_data, NTT_INPUT;
  logic [1:0]      in_op_type, OP_TYPE_INPUT;
  logic [LOGQ-1:0] in_q, Q_in;

  tp_ntt_feeder #(.N(N), .TP(TP), .LOGQ(LOGQ), .MIN_GAP(MIN_GAP)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_op_type    (in_op_type),
    .in_q          (in_q),
    .START_NTT_ALL (START_NTT_ALL),
    .OP_TYPE_INPUT (OP_TYPE_INPUT),
    .Q_in          (Q_in),
    .NTT_INPUT     (NTT_INPUT),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]    data;
    logic [1:0]      op;
    logic [LOGQ-1:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   start_edges[$];
  int   mon_left = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  exp_t mon_e;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_beat(input int base, input int beat, input bit special);
    logic [W-1:0] d;
    d = '0;
    for (int l = 0; l < TP; l++) d[l*LOGQ +: LOGQ] = 32'(base + beat * TP + l);
    if (special) begin
      d[0 +: LOGQ]    = 32'd150;
      d[LOGQ +: LOGQ] = 32'd96;
    end
    return d;
  endfunction

  // Reference for what a stored lane should look like.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [LOGQ-1:0] q);
    logic [W-1:0] r;
    r = d;
`ifdef TP_NTT_FEEDER_CSUB_EN
    for (int l = 0; l < TP; l++)
      if (d[l*LOGQ +: LOGQ] >= q) r[l*LOGQ +: LOGQ] = d[l*LOGQ +: LOGQ] - q;
`endif
    return r;
  endfunction

  // Output monitor: each START opens a DEPTH-beat window checked against the queue.
  always @(negedge clk) begin
    if (rst) begin
      mon_left = 0;
    end else begin
      if (START_NTT_ALL === 1'b1) begin
        chk("start_mid_stream", W'(mon_left), W'(0));
        start_edges.push_back(cyc);
        mon_left = DEPTH;
      end
      if (mon_left > 0) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", W'(1), W'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("stream_data", NTT_INPUT, mon_e.data);
          chk("stream_op", W'(OP_TYPE_INPUT), W'(mon_e.op));
          chk("stream_q", W'(Q_in), W'(mon_e.q));
        end
        mon_left = mon_left - 1;
      end else begin
        chk("idle_data_zero", NTT_INPUT, '0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_beat(input logic [W-1:0] d, input logic [1:0] op,
                           input logic [LOGQ-1:0] q, output int hs);
    exp_t e;
    int   t;
    in_valid   = 1'b1;
    in_data    = d;
    in_op_type = op;
    in_q       = q;
    t = 0;
    while (in_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("hs_ready", W'(in_ready), W'(1));
    e.data = model(d, q);
    e.op   = op;
    e.q    = q;
    exp_q.push_back(e);
    hs = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_poly(input int base, input logic [1:0] op, input logic [LOGQ-1:0] q,
                           input bit gappy, input bit special, output int last_hs);
    int hs;
    hs = 0;
    for (int b = 0; b < DEPTH; b++) begin
      send_beat(mk_beat(base, b, special), op, q, hs);
      if (gappy) @(negedge clk);
    end
    last_hs = hs;
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_left != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", W'(t < 400), W'(1));
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, W'(START_NTT_ALL), W'(0));
    chk({tag, "_data"}, NTT_INPUT, '0);
    chk({tag, "_op"}, W'(OP_TYPE_INPUT), W'(0));
    chk({tag, "_q"}, W'(Q_in), W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_ready"}, W'(in_ready), W'(0));
  endtask

  initial begin
    int ns, h, h0, h1, h2, t;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op_type = '0; in_q = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    #1 chk("ready_before_edge", W'(in_ready), W'(0));
    @(posedge clk);
    #1 chk("ready_after_edge", W'(in_ready), W'(1));
    @(negedge clk);

    // Single gapless polynomial.
    ns = start_edges.size();
    send_poly(0, 2'd1, 32'd97, 1'b0, 1'b0, h);
    chk("t1_busy", W'(busy), W'(1));
    wait_drained();
    chk("t1_start_count", W'(start_edges.size() - ns), W'(1));
    if (start_edges.size() > ns) chk("t1_start_lat", W'(start_edges[ns]), W'(h + 2));
    chk("t1_op_hold", W'(OP_TYPE_INPUT), W'(1));
    chk("t1_q_hold", W'(Q_in), W'(97));
    chk("t1_busy_idle", W'(busy), W'(0));

    // Three back-to-back polynomials.
    ns = start_edges.size();
    send_poly(1000, 2'd2, 32'd101, 1'b0, 1'b0, h0);
    send_poly(2000, 2'd3, 32'd103, 1'b0, 1'b0, h1);
    chk("t2_ready_low", W'(in_ready), W'(0));
    send_poly(3000, 2'd0, 32'd107, 1'b0, 1'b0, h2);
    wait_drained();
    chk("t2_start_count", W'(start_edges.size() - ns), W'(3));
    if (start_edges.size() >= ns + 3) begin
      chk("t2_start0_lat", W'(start_edges[ns]), W'(h0 + 2));
      chk("t2_gap01", W'(start_edges[ns+1] - start_edges[ns]), W'(MIN_GAP));
      chk("t2_gap12", W'(start_edges[ns+2] - start_edges[ns+1]), W'(MIN_GAP));
    end

    // in_valid toggled every other cycle.
    ns = start_edges.size();
    send_poly(4000, 2'd1, 32'd97, 1'b1, 1'b0, h);
    wait_drained();
    chk("t3_start_count", W'(start_edges.size() - ns), W'(1));
    if (start_edges.size() > ns) chk("t3_start_lat", W'(start_edges[ns]), W'(h + 2));

    // Reset after beat 7 of a fill.
    for (int b = 0; b < 8; b++) send_beat(mk_beat(7000, b, 1'b0), 2'd3, 32'd89, h);
    #2 rst = 1'b1;
    #1 chk_all_zero("t4_rst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ns = start_edges.size();
    repeat (60) @(negedge clk);
    chk("t4_no_start", W'(start_edges.size() - ns), W'(0));
    chk("t4_busy", W'(busy), W'(0));

    // Reset during beat 5 of a stream.
    ns = start_edges.size();
    send_poly(5000, 2'd2, 32'd113, 1'b0, 1'b0, h);
    t = 0;
    do begin
      @(posedge clk);
      #1 t++;
    end while (START_NTT_ALL !== 1'b1 && t < 100);
    chk("t5_start_seen", W'(START_NTT_ALL), W'(1));
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all_zero("t5_rst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("t5_no_restart", W'(start_edges.size() - ns), W'(1));

    // Fresh polynomial after reset behaves normally.
    ns = start_edges.size();
    send_poly(6000, 2'd1, 32'd97, 1'b0, 1'b0, h);
    wait_drained();
    chk("t6_start_count", W'(start_edges.size() - ns), W'(1));
    if (start_edges.size() > ns) chk("t6_start_lat", W'(start_edges[ns]), W'(h + 2));

    // Lane conditioning: 150 and 96 with q = 97.
    send_poly(0, 2'd1, 32'd97, 1'b0, 1'b1, h);
    t = 0;
    do begin
      @(posedge clk);
      #1 t++;
    end while (START_NTT_ALL !== 1'b1 && t < 100);
`ifdef TP_NTT_FEEDER_CSUB_EN
    chk("t7_lane150", W'(NTT_INPUT[31:0]), W'(53));
`else
    chk("t7_lane150", W'(NTT_INPUT[31:0]), W'(150));
`endif
    chk("t7_lane96", W'(NTT_INPUT[63:32]), W'(96));
    @(negedge clk);
    wait_drained();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
